// File: rtl/aperture_bridge_pkg.sv
// Shared definitions for the aperture bridge: config page, FSM states and
// the aperture address translation helper.
package aperture_bridge_pkg;

  localparam logic [7:0]  CFG_PAGE   = 8'hFF;
  localparam int unsigned NUM_AP_DEF = 16;
  localparam int unsigned AP_IDX_W   = $clog2(NUM_AP_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_DATA,
    S_WR_REQ
  } bridge_state_t;

  // Page offset wraps mod 256; the final byte address wraps mod 2^32.
  function automatic logic [31:0] ap_translate(input logic [31:0] base,
                                               input logic [7:0]  lo,
                                               input logic [15:0] addr);
    logic [7:0] page;
    page = addr[15:8] - lo;
    return base + {16'h0000, page, addr[7:0]};
  endfunction

endpackage

// File: rtl/aperture_bridge_sel.sv
// Priority select over per-aperture hit flags: lowest set index wins.
module ap_priority_sel #(
  parameter int unsigned NUM_AP = 16,
  parameter int unsigned IDX_W  = 4
) (
  input  logic [NUM_AP-1:0] i_hit,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned i = 0; i < NUM_AP; i++) begin
      if (i_hit[i] && !o_any) begin
        o_idx = IDX_W'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aperture_bridge.sv
// Bridges A8 accesses that hit an enabled aperture into single SDRAM byte
// reads/writes, returning read data to the host bus drivers.
module aperture_bridge
  import aperture_bridge_pkg::*;
#(
  parameter int unsigned NUM_AP = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a8_rw_n,
  input  logic [15:0]          a8_addr,
  input  logic [7:0]           a8_data,
  input  logic                 aValid,
  input  logic                 wValid,
  input  logic [NUM_AP-1:0]    apHit,
  input  logic [32*NUM_AP-1:0] apBase,
  input  logic [8*NUM_AP-1:0]  apLo,
  output logic                 sd_req,
  output logic                 sd_we,
  output logic [31:0]          sd_addr,
  output logic [7:0]           sd_wdata,
  input  logic                 sd_ack,
  input  logic [7:0]           sd_rdata,
  input  logic                 sd_rvalid,
  output logic [7:0]           busData,
  output logic                 busDataValid,
  output logic                 busy,
  output logic                 lateRead
);

  localparam int unsigned IDX_W = (NUM_AP > 1) ? $clog2(NUM_AP) : 1;

  bridge_state_t    r_state, w_state_nxt;
  logic             r_aval_q;
  logic [31:0]      r_sd_addr;
  logic [7:0]       r_sd_wdata;
  logic [7:0]       r_bus_data;
  logic             r_bus_valid;
  logic             r_late;

  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic [31:0]      w_base;
  logic [7:0]       w_lo;
  logic             w_start;
  logic             w_rd_done;
  logic             w_wr_latch;

  ap_priority_sel #(
    .NUM_AP (NUM_AP),
    .IDX_W  (IDX_W)
  ) u_sel (
    .i_hit (apHit),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_base  = apBase[{w_idx, 5'b00000} +: 32];
  assign w_lo    = apLo[{w_idx, 3'b000} +: 8];
  assign w_start = aValid && !r_aval_q && w_any && (a8_addr[15:8] != CFG_PAGE);

  always_comb begin
    w_state_nxt = r_state;
    w_rd_done   = 1'b0;
    w_wr_latch  = 1'b0;
    case (r_state)
      S_IDLE:
        if (w_start) w_state_nxt = a8_rw_n ? S_RD_REQ : S_WR_DATA;
      S_RD_REQ:
        if (sd_ack) begin
          // ack and rvalid together complete the read in this same cycle
          if (sd_rvalid) begin
            w_rd_done   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RD_WAIT;
          end
        end
      S_RD_WAIT:
        if (sd_rvalid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      S_WR_DATA:
        if (wValid) begin
          w_wr_latch  = 1'b1;
          w_state_nxt = S_WR_REQ;
        end else if (!aValid) begin
          w_state_nxt = S_IDLE;
        end
      S_WR_REQ:
        if (sd_ack) w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_aval_q    <= 1'b0;
      r_sd_addr   <= '0;
      r_sd_wdata  <= '0;
      r_bus_data  <= '1;
      r_bus_valid <= 1'b0;
      r_late      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_aval_q    <= aValid;
      r_bus_valid <= 1'b0;
      r_late      <= 1'b0;
      if (r_state == S_IDLE && w_start) r_sd_addr <= ap_translate(w_base, w_lo, a8_addr);
      if (w_wr_latch) r_sd_wdata <= a8_data;
      if (w_rd_done) begin
        if (aValid) begin
          r_bus_data  <= sd_rdata;
          r_bus_valid <= 1'b1;
        end else begin
          r_late      <= 1'b1;
        end
      end
    end
  end

  assign sd_req       = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign sd_we        = (r_state == S_WR_REQ);
  assign sd_addr      = r_sd_addr;
  assign sd_wdata     = r_sd_wdata;
  assign busData      = r_bus_data;
  assign busDataValid = r_bus_valid;
  assign lateRead     = r_late;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_aperture_bridge.sv
// Scoreboard bench for aperture_bridge: stimulus pushes expected SDRAM
// requests and bus results; monitors pop and compare on DUT output events.
module tb_aperture_bridge;

  logic          clk = 1'b0;
  logic          rst;
  logic          a8_rw_n;
  logic [15:0]   a8_addr;
  logic [7:0]    a8_data;
  logic          aValid;
  logic          wValid;
  logic [15:0]   apHit;
  logic [511:0]  apBase;
  logic [127:0]  apLo;
  logic          sd_req, sd_we;
  logic [31:0]   sd_addr;
  logic [7:0]    sd_wdata;
  logic          sd_ack;
  logic [7:0]    sd_rdata;
  logic          sd_rvalid;
  logic [7:0]    busData;
  logic          busDataValid, busy, lateRead;

  int tests = 0;
  int fails = 0;

  typedef struct { logic we; logic [31:0] addr; logic [7:0] wdata; } req_t;
  typedef struct { logic late; logic [7:0] data; } bus_t;
  req_t req_q[$];
  bus_t bus_q[$];

  // responder controls
  logic       resp_en     = 1'b1;
  int         ack_dly     = 0;
  logic       rv_with_ack = 1'b0;
  logic [7:0] rd_byte     = 8'h00;
  int         ghost_req   = 0;
  int         ghost_done  = 0;

  always #5 clk = ~clk;

  aperture_bridge #(.NUM_AP(16)) dut (
    .clk(clk), .rst(rst), .a8_rw_n(a8_rw_n), .a8_addr(a8_addr), .a8_data(a8_data),
    .aValid(aValid), .wValid(wValid), .apHit(apHit), .apBase(apBase), .apLo(apLo),
    .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_ack(sd_ack), .sd_rdata(sd_rdata), .sd_rvalid(sd_rvalid),
    .busData(busData), .busDataValid(busDataValid), .busy(busy), .lateRead(lateRead)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM controller model
  initial begin
    logic rd;
    sd_ack = 1'b0; sd_rvalid = 1'b0; sd_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (ghost_req != ghost_done) begin
        sd_ack = 1'b1; sd_rvalid = 1'b1; sd_rdata = 8'hEE;
        @(negedge clk);
        sd_ack = 1'b0; sd_rvalid = 1'b0;
        ghost_done++;
      end else if (sd_req && resp_en) begin
        rd = !sd_we;
        repeat (ack_dly) @(negedge clk);
        sd_ack = 1'b1;
        if (rd && rv_with_ack) begin sd_rvalid = 1'b1; sd_rdata = rd_byte; end
        @(negedge clk);
        sd_ack = 1'b0; sd_rvalid = 1'b0;
        if (rd && !rv_with_ack) begin
          sd_rvalid = 1'b1; sd_rdata = rd_byte;
          @(negedge clk);
          sd_rvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: SDRAM request side and bus result side
  initial begin
    logic prev_req = 1'b0;
    req_t cur = '{we: 1'b0, addr: 32'h0, wdata: 8'h0};
    forever begin
      @(negedge clk);
      if (sd_req && !prev_req) begin
        if (req_q.size() == 0) chk("unexpected_req", {31'h0, sd_req}, 32'h0);
        else begin
          cur = req_q.pop_front();
          chk("req_we", {31'h0, sd_we}, {31'h0, cur.we});
          chk("req_addr", sd_addr, cur.addr);
          if (cur.we) chk("req_wdata", {24'h0, sd_wdata}, {24'h0, cur.wdata});
        end
      end else if (sd_req) begin
        chk("req_stable_addr", sd_addr, cur.addr);
        chk("req_stable_we", {31'h0, sd_we}, {31'h0, cur.we});
      end
      prev_req = sd_req;
      if (busDataValid || lateRead) begin
        if (bus_q.size() == 0) chk("unexpected_bus", {30'h0, busDataValid, lateRead}, 32'h0);
        else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_kind", {30'h0, busDataValid, lateRead}, {30'h0, !b.late, b.late});
          chk("bus_data", {24'h0, busData}, {24'h0, b.data});
        end
      end
    end
  end

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    chk("idle_timeout", {31'h0, busy}, 32'h0);
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] hit);
    @(negedge clk);
    apHit = hit; a8_rw_n = 1'b1; a8_addr = addr; aValid = 1'b1;
    @(negedge clk);
    wait_idle(60);
    aValid = 1'b0; apHit = '0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] d, input logic [15:0] hit);
    @(negedge clk);
    apHit = hit; a8_rw_n = 1'b0; a8_addr = addr; aValid = 1'b1;
    @(negedge clk);
    a8_data = d; wValid = 1'b1;
    @(negedge clk);
    wait_idle(60);
    wValid = 1'b0; aValid = 1'b0; apHit = '0;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sd_req"}, {31'h0, sd_req}, 32'h0);
    chk({tag, "_sd_we"}, {31'h0, sd_we}, 32'h0);
    chk({tag, "_sd_addr"}, sd_addr, 32'h0);
    chk({tag, "_sd_wdata"}, {24'h0, sd_wdata}, 32'h0);
    chk({tag, "_busData"}, {24'h0, busData}, 32'hFF);
    chk({tag, "_strobes"}, {29'h0, busDataValid, lateRead, busy}, 32'h0);
  endtask

  initial begin
    int busy_seen;
    rst = 1'b1; a8_rw_n = 1'b1; a8_addr = '0; a8_data = '0;
    aValid = 1'b0; wValid = 1'b0; apHit = '0; apBase = '0; apLo = '0;
    apBase[0*32 +: 32] = 32'h0010_0000; apLo[0*8 +: 8] = 8'h40;
    apBase[3*32 +: 32] = 32'hFFFF_FF00; apLo[3*8 +: 8] = 8'h80;
    apBase[2*32 +: 32] = 32'h0200_0000; apLo[2*8 +: 8] = 8'h60;
    apBase[5*32 +: 32] = 32'h0500_0000; apLo[5*8 +: 8] = 8'h60;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");

    // 1: read hit on ap0
    rd_byte = 8'h5A;
    req_q.push_back('{we: 1'b0, addr: 32'h0010_0123, wdata: 8'h00});
    bus_q.push_back('{late: 1'b0, data: 8'h5A});
    do_read(16'h4123, 16'h0001);

    // 2: write on ap3 with 32-bit address wrap
    req_q.push_back('{we: 1'b1, addr: 32'h0000_0010, wdata: 8'hC3});
    do_write(16'h8110, 8'hC3, 16'h0008);

    // 3: overlapping hits, lowest index (ap2) wins
    rd_byte = 8'h77;
    req_q.push_back('{we: 1'b0, addr: 32'h0200_0000, wdata: 8'h00});
    bus_q.push_back('{late: 1'b0, data: 8'h77});
    do_read(16'h6000, 16'h0024);

    // page below apLo wraps mod 256; ack and rvalid arrive together
    rd_byte = 8'hA1; rv_with_ack = 1'b1;
    req_q.push_back('{we: 1'b0, addr: 32'h0010_D005, wdata: 8'h00});
    bus_q.push_back('{late: 1'b0, data: 8'hA1});
    do_read(16'h1005, 16'h0001);
    rv_with_ack = 1'b0;

    // 4: config page never bridged
    @(negedge clk);
    apHit = 16'h0001; a8_rw_n = 1'b1; a8_addr = 16'hFF12; aValid = 1'b1;
    busy_seen = 0;
    repeat (6) begin @(negedge clk); if (busy) busy_seen++; end
    chk("cfg_busy", busy_seen, 0);
    aValid = 1'b0; apHit = '0;
    @(negedge clk);

    // 5: write aborted before data, then a normal read
    apHit = 16'h0001; a8_rw_n = 1'b0; a8_addr = 16'h4050; aValid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_wrdata", {31'h0, busy}, 32'h1);
    aValid = 1'b0; apHit = '0;
    @(negedge clk);
    chk("abort_idle", {31'h0, busy}, 32'h0);
    rd_byte = 8'h3C;
    req_q.push_back('{we: 1'b0, addr: 32'h0010_0001, wdata: 8'h00});
    bus_q.push_back('{late: 1'b0, data: 8'h3C});
    do_read(16'h4001, 16'h0001);

    // 6: reset, then a late read leaves busData at its reset value
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset2");
    ack_dly = 10; rd_byte = 8'hE7;
    req_q.push_back('{we: 1'b0, addr: 32'h0010_0123, wdata: 8'h00});
    bus_q.push_back('{late: 1'b1, data: 8'hFF});
    apHit = 16'h0001; a8_rw_n = 1'b1; a8_addr = 16'h4123; aValid = 1'b1;
    repeat (4) @(negedge clk);
    aValid = 1'b0; apHit = '0;
    wait_idle(60);
    repeat (2) @(negedge clk);
    ack_dly = 0;

    // reset while in RD_REQ; stale ack/rvalid afterwards must be ignored
    resp_en = 1'b0;
    req_q.push_back('{we: 1'b0, addr: 32'h0010_0123, wdata: 8'h00});
    apHit = 16'h0001; a8_rw_n = 1'b1; a8_addr = 16'h4123; aValid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rdreq_held", {31'h0, sd_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midreset");
    rst = 1'b0; aValid = 1'b0; apHit = '0;
    ghost_req++;
    repeat (4) @(negedge clk);
    chk("ghost_ignored", {29'h0, busy, busDataValid, lateRead}, 32'h0);
    resp_en = 1'b1;

    repeat (3) @(negedge clk);
    chk("req_q_empty", req_q.size(), 0);
    chk("bus_q_empty", bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
